// File: rtl/branch_pc_unit.sv
// branch_pc_unit: resolves the branch condition, selects the next PC, sequences misaligned-target traps and counts branches.
module branch_pc_unit #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_ready,
  input  logic             is_branch,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic [2:0]       funct3,
  input  logic             BrEq,
  input  logic             BrLT,
  input  logic [31:0]      alu_out,
  output logic             BrUn,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             PCSel,
  output logic             instr_valid,
  output logic             trap,
  output logic [31:0]      trap_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] br_taken_count
);
  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_TRAP = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d, trap_pc_q, trap_pc_d, target;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d, tk_cnt_q, tk_cnt_d;
  logic             taken, jump, cond, cnt_en;
  always_comb begin
    BrUn        = funct3[1];
    // funct3[0] inverts the sense; 010/011 never take
    taken       = funct3[2] ? (BrLT ^ funct3[0]) : (funct3[1] ? 1'b0 : (BrEq ^ funct3[0]));
    jump        = is_jal | is_jalr;
    cond        = is_branch & ~jump;
    instr_valid = (state_q == S_RUN) & imem_ready;
    target      = is_jalr ? (alu_out & ~32'h1) : alu_out;
    pc_plus4    = pc_q + 32'd4;
    PCSel       = instr_valid & (jump | (cond & taken));
    trap        = PCSel & target[1];
    cnt_en      = instr_valid & cond & ~trap;
    state_d     = (state_q == S_RUN && trap) ? S_TRAP : S_RUN;
    pc_d        = instr_valid ? (trap ? TRAP_VEC : (PCSel ? target : pc_plus4)) : pc_q;
    trap_pc_d   = trap ? pc_q : trap_pc_q;
    br_cnt_d    = (cnt_en && br_cnt_q != '1) ? br_cnt_q + CNT_W'(1) : br_cnt_q;
    tk_cnt_d    = (cnt_en && taken && tk_cnt_q != '1) ? tk_cnt_q + CNT_W'(1) : tk_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_BOOT;
      pc_q      <= RESET_VEC;
      trap_pc_q <= '0;
      br_cnt_q  <= '0;
      tk_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      trap_pc_q <= trap_pc_d;
      br_cnt_q  <= br_cnt_d;
      tk_cnt_q  <= tk_cnt_d;
    end
  end
  assign pc             = pc_q;
  assign trap_pc        = trap_pc_q;
  assign br_count       = br_cnt_q;
  assign br_taken_count = tk_cnt_q;
endmodule
